// File: rtl/sm83_mem_map.sv
// rtl/sm83_mem_map.sv - SM83 address decoder, boot overlay, HRAM and fixed-latency read path
// Every read completes MEM_LAT+1 clocks after accept, whichever region it hits.
module sm83_mem_map #(
  parameter int          MEM_LAT       = 1,
  parameter int          BOOT_AW       = 8,
  parameter int          WRAM_AW       = 13,
  parameter bit          ECHO_EN       = 1'b1,
  parameter logic [15:0] BOOT_DIS_ADDR = 16'hFF50,
  parameter logic [7:0]  OPEN_BUS      = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_wdata,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_rvalid,
  output logic               busy,
  output logic               boot_active,
  output logic               boot_en,
  output logic [BOOT_AW-1:0] boot_addr,
  input  logic [7:0]         boot_dout,
  output logic               cart_en,
  output logic [14:0]        cart_addr,
  input  logic [7:0]         cart_dout,
  output logic               wram_en,
  output logic               wram_we,
  output logic [WRAM_AW-1:0] wram_addr,
  output logic [7:0]         wram_din,
  input  logic [7:0]         wram_dout
);

  typedef enum logic [2:0] {
    RG_BOOT, RG_CART, RG_WRAM, RG_BOOTREG, RG_HRAM, RG_OPEN
  } region_t;

  logic [MEM_LAT-1:0] pipe_v;
  region_t            pipe_tag [MEM_LAT];
  logic [7:0]         pipe_dat [MEM_LAT];
  logic [7:0]         hram [127];

  region_t    region;
  logic       accept;
  logic       is_rd;
  logic       is_wr;
  logic [7:0] int_dat;
  logic [7:0] rd_mux;

  assign busy   = |pipe_v;
  assign accept = !rst && !busy && (cpu_rd || cpu_wr);
  assign is_wr  = accept && cpu_wr;
  assign is_rd  = accept && cpu_rd && !cpu_wr;

  always_comb begin
    region = RG_OPEN;
    if (boot_active && ({1'b0, cpu_addr} < (17'd1 << BOOT_AW)))
      region = RG_BOOT;
    else if (!cpu_addr[15])
      region = RG_CART;
    else if (cpu_addr[15:13] == 3'b110)
      region = RG_WRAM;
    else if (ECHO_EN && cpu_addr >= 16'hE000 && cpu_addr <= 16'hFDFF)
      region = RG_WRAM;
    else if (cpu_addr == BOOT_DIS_ADDR)
      region = RG_BOOTREG;
    else if (cpu_addr >= 16'hFF80 && cpu_addr != 16'hFFFF)
      region = RG_HRAM;
  end

  // Memory strobes exist only in the accept cycle; ROMs never see writes.
  assign boot_en   = is_rd && (region == RG_BOOT);
  assign boot_addr = boot_en ? cpu_addr[BOOT_AW-1:0] : '0;
  assign cart_en   = is_rd && (region == RG_CART);
  assign cart_addr = cart_en ? cpu_addr[14:0] : '0;
  assign wram_en   = (is_rd || is_wr) && (region == RG_WRAM);
  assign wram_we   = is_wr && (region == RG_WRAM);
  assign wram_addr = wram_en ? cpu_addr[WRAM_AW-1:0] : '0;
  assign wram_din  = wram_we ? cpu_wdata : '0;

  assign int_dat = (region == RG_HRAM) ? hram[cpu_addr[6:0]] : {7'b1111111, ~boot_active};

  always_comb begin
    rd_mux = OPEN_BUS;
    case (pipe_tag[MEM_LAT-1])
      RG_BOOT:              rd_mux = boot_dout;
      RG_CART:              rd_mux = cart_dout;
      RG_WRAM:              rd_mux = wram_dout;
      RG_BOOTREG, RG_HRAM:  rd_mux = pipe_dat[MEM_LAT-1];
      default:              rd_mux = OPEN_BUS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v      <= '0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= OPEN_BUS;
      boot_active <= 1'b1;
    end else begin
      pipe_v[0] <= is_rd;
      for (int i = 1; i < MEM_LAT; i++)
        pipe_v[i] <= pipe_v[i-1];
      cpu_rvalid <= pipe_v[MEM_LAT-1];
      if (pipe_v[MEM_LAT-1])
        cpu_rdata <= rd_mux;
      if (is_wr && (region == RG_BOOTREG) && (cpu_wdata != 8'h00))
        boot_active <= 1'b0;
    end
  end

  // Tag and internal byte travel alongside the external RAM latency; pipe_v qualifies them.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= region;
    pipe_dat[0] <= int_dat;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
      pipe_dat[i] <= pipe_dat[i-1];
    end
    if (is_wr && (region == RG_HRAM))
      hram[cpu_addr[6:0]] <= cpu_wdata;
  end

endmodule

// File: tb/tb_sm83_mem_map.sv
// tb/tb_sm83_mem_map.sv - directed bench with a region-level reference model and scoreboard
module tb_sm83_mem_map;
  localparam int LAT = 2;
  localparam int R_BOOT = 0, R_CART = 1, R_WRAM = 2, R_BREG = 3, R_HRAM = 4, R_OPEN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic cpu_rd = 1'b0, cpu_wr = 1'b0;

  logic [7:0] rdata1, rdata2, boot_dout1, boot_dout2, cart_dout1, cart_dout2;
  logic [7:0] wram_din1, wram_din2, wram_dout1, wram_dout2, boot_addr1, boot_addr2;
  logic rvalid1, rvalid2, busy1, busy2, ba1, ba2, boot_en1, boot_en2, cart_en1, cart_en2;
  logic wram_en1, wram_en2, wram_we1, wram_we2;
  logic [14:0] cart_addr1, cart_addr2;
  logic [12:0] wram_addr1, wram_addr2;

  always #5 clk = ~clk;

  sm83_mem_map #(.MEM_LAT(LAT), .BOOT_AW(8), .WRAM_AW(13), .ECHO_EN(1'b1),
                 .BOOT_DIS_ADDR(16'hFF50), .OPEN_BUS(8'hFF)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_rdata(rdata1), .cpu_rvalid(rvalid1), .busy(busy1),
    .boot_active(ba1), .boot_en(boot_en1), .boot_addr(boot_addr1), .boot_dout(boot_dout1),
    .cart_en(cart_en1), .cart_addr(cart_addr1), .cart_dout(cart_dout1), .wram_en(wram_en1),
    .wram_we(wram_we1), .wram_addr(wram_addr1), .wram_din(wram_din1), .wram_dout(wram_dout1));

  sm83_mem_map #(.MEM_LAT(1), .BOOT_AW(8), .WRAM_AW(13), .ECHO_EN(1'b0),
                 .BOOT_DIS_ADDR(16'hFF50), .OPEN_BUS(8'hFF)) dut_noecho (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_rdata(rdata2), .cpu_rvalid(rvalid2), .busy(busy2),
    .boot_active(ba2), .boot_en(boot_en2), .boot_addr(boot_addr2), .boot_dout(boot_dout2),
    .cart_en(cart_en2), .cart_addr(cart_addr2), .cart_dout(cart_dout2), .wram_en(wram_en2),
    .wram_we(wram_we2), .wram_addr(wram_addr2), .wram_din(wram_din2), .wram_dout(wram_dout2));

  function automatic logic [7:0] boot_fn(input logic [7:0] a);
    return 8'h31 + a;
  endfunction

  function automatic logic [7:0] cart_fn(input logic [14:0] a);
    return 8'hC3 ^ a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  // External synchronous memories (LAT stages for dut, one stage for dut_noecho)
  logic [7:0] wmem1 [8192];
  logic [7:0] wmem2 [8192];
  logic [7:0] bp1 [LAT];
  logic [7:0] cp1 [LAT];
  logic [7:0] wp1 [LAT];
  logic [7:0] bq2, cq2, wq2;

  always @(posedge clk) begin
    bp1[0] <= boot_en1 ? boot_fn(boot_addr1) : 8'hE1;
    cp1[0] <= cart_en1 ? cart_fn(cart_addr1) : 8'hE2;
    wp1[0] <= wram_en1 ? wmem1[wram_addr1] : 8'hE3;
    if (wram_we1) wmem1[wram_addr1] <= wram_din1;
    for (int i = 1; i < LAT; i++) begin
      bp1[i] <= bp1[i-1];
      cp1[i] <= cp1[i-1];
      wp1[i] <= wp1[i-1];
    end
    bq2 <= boot_en2 ? boot_fn(boot_addr2) : 8'hE1;
    cq2 <= cart_en2 ? cart_fn(cart_addr2) : 8'hE2;
    wq2 <= wram_en2 ? wmem2[wram_addr2] : 8'hE3;
    if (wram_we2) wmem2[wram_addr2] <= wram_din2;
  end

  assign boot_dout1 = bp1[LAT-1];
  assign cart_dout1 = cp1[LAT-1];
  assign wram_dout1 = wp1[LAT-1];
  assign boot_dout2 = bq2;
  assign cart_dout2 = cq2;
  assign wram_dout2 = wq2;

  // Reference model state
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         chk_on = 1'b0;
  bit         m_boot = 1'b1;
  logic [7:0] m_rdata = 8'hFF;
  logic [7:0] m_wram [8192];
  logic [7:0] m_hram [127];
  int         q_due [$];
  logic [7:0] q_dat [$];
  int         busy_from = -1, busy_to = -2;
  logic       e_boot_en = 0, e_cart_en = 0, e_wram_en = 0, e_wram_we = 0;
  logic [7:0] e_boot_addr = 0, e_wram_din = 0;
  logic [14:0] e_cart_addr = 0;
  logic [12:0] e_wram_addr = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int region_of(input logic [15:0] a, input bit ba);
    if (ba && a < 16'h0100) return R_BOOT;
    if (a < 16'h8000) return R_CART;
    if (a >= 16'hC000 && a <= 16'hFDFF) return R_WRAM;
    if (a == 16'hFF50) return R_BREG;
    if (a >= 16'hFF80 && a <= 16'hFFFE) return R_HRAM;
    return R_OPEN;
  endfunction

  function automatic logic [7:0] rd_expect(input logic [15:0] a, input int r);
    case (r)
      R_BOOT:  return boot_fn(a[7:0]);
      R_CART:  return cart_fn(a[14:0]);
      R_WRAM:  return m_wram[a[12:0]];
      R_BREG:  return {7'h7F, ~m_boot};
      R_HRAM:  return m_hram[a[6:0]];
      default: return 8'hFF;
    endcase
  endfunction

  always @(negedge clk) begin : cmp
    bit ev;
    if (chk_on) begin
      ev = (q_due.size() > 0) && (q_due[0] == cyc);
      chk("rvalid", 16'(rvalid1), 16'(ev));
      if (ev) begin
        m_rdata = q_dat[0];
        void'(q_due.pop_front());
        void'(q_dat.pop_front());
      end
      chk("rdata", 16'(rdata1), 16'(m_rdata));
      chk("busy", 16'(busy1), 16'(cyc >= busy_from && cyc <= busy_to));
      chk("boot_active", 16'(ba1), 16'(m_boot));
      chk("boot_en", 16'(boot_en1), 16'(e_boot_en));
      chk("boot_addr", 16'(boot_addr1), 16'(e_boot_addr));
      chk("cart_en", 16'(cart_en1), 16'(e_cart_en));
      chk("cart_addr", 16'(cart_addr1), 16'(e_cart_addr));
      chk("wram_en", 16'(wram_en1), 16'(e_wram_en));
      chk("wram_we", 16'(wram_we1), 16'(e_wram_we));
      chk("wram_addr", 16'(wram_addr1), 16'(e_wram_addr));
      chk("wram_din", 16'(wram_din1), 16'(e_wram_din));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d,
                     input bit probe2);
    int n, r, acc;
    logic [7:0] ed;
    n = 0;
    while (busy1 === 1'b1 && n < 20) begin step(1); n++; end
    chk("busy_wait_bound", 16'(n >= 20), 16'd0);
    r   = region_of(a, m_boot);
    acc = cyc;
    ed  = rd_expect(a, r);
    cpu_addr = a; cpu_wdata = d; cpu_rd = rd; cpu_wr = wr;
    e_boot_en   = rd && !wr && (r == R_BOOT);
    e_boot_addr = e_boot_en ? a[7:0] : 8'h00;
    e_cart_en   = rd && !wr && (r == R_CART);
    e_cart_addr = e_cart_en ? a[14:0] : 15'h0;
    e_wram_en   = (rd || wr) && (r == R_WRAM);
    e_wram_we   = wr && (r == R_WRAM);
    e_wram_addr = e_wram_en ? a[12:0] : 13'h0;
    e_wram_din  = e_wram_we ? d : 8'h00;
    if (probe2) begin
      @(negedge clk);
      chk("noecho_wram_en", 16'(wram_en2), 16'd0);
    end
    @(posedge clk);
    if (wr) begin
      if (r == R_WRAM) m_wram[a[12:0]] = d;
      if (r == R_HRAM) m_hram[a[6:0]] = d;
      if (r == R_BREG && d != 8'h00) m_boot = 1'b0;
    end else if (rd) begin
      q_due.push_back(acc + LAT + 1);
      q_dat.push_back(ed);
      busy_from = acc + 1;
      busy_to   = acc + LAT;
    end
    #1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    e_boot_en = 0; e_cart_en = 0; e_wram_en = 0; e_wram_we = 0;
    e_boot_addr = 0; e_cart_addr = 0; e_wram_addr = 0; e_wram_din = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("reset_rdata", 16'(rdata1), 16'h00FF);
    chk("reset_rvalid", 16'(rvalid1), 16'd0);
    chk("reset_busy", 16'(busy1), 16'd0);
    chk("reset_boot_active", 16'(ba1), 16'd1);

    // boot overlay read
    req(1, 0, 16'h0000, 8'h00, 0);
    step(LAT);
    chk("boot_read_rvalid", 16'(rvalid1), 16'd1);
    chk("boot_read_data", 16'(rdata1), 16'h0031);

    // WRAM write then echo read; the no-echo instance must answer open bus
    req(0, 1, 16'hC123, 8'hA5, 0);
    chk("wram_written", 16'(wmem1[13'h0123]), 16'h00A5);
    req(1, 0, 16'hE123, 8'h00, 1);
    step(LAT);
    chk("echo_read_data", 16'(rdata1), 16'h00A5);
    chk("noecho_read_data", 16'(rdata2), 16'h00FF);

    // zero write leaves the overlay on, nonzero write turns it off
    req(0, 1, 16'hFF50, 8'h00, 0);
    chk("bootreg_zero_write", 16'(ba1), 16'd1);
    req(0, 1, 16'hFF50, 8'h01, 0);
    chk("bootreg_disable", 16'(ba1), 16'd0);
    req(1, 0, 16'h0000, 8'h00, 0);
    step(LAT);
    chk("cart_read_data", 16'(rdata1), 16'h00C3);
    req(1, 0, 16'hFF50, 8'h00, 0);
    step(LAT);
    chk("bootreg_read", 16'(rdata1), 16'h00FF);

    // HRAM ends, read back-to-back
    req(0, 1, 16'hFF80, 8'h5A, 0);
    req(0, 1, 16'hFFFE, 8'h3C, 0);
    req(1, 0, 16'hFF80, 8'h00, 0);
    step(LAT);
    chk("hram_lo_rvalid", 16'(rvalid1), 16'd1);
    chk("hram_lo_data", 16'(rdata1), 16'h005A);
    chk("hram_lo_busy", 16'(busy1), 16'd0);
    req(1, 0, 16'hFFFE, 8'h00, 0);
    step(LAT);
    chk("hram_hi_data", 16'(rdata1), 16'h003C);

    // open bus and ignored ROM write
    req(1, 0, 16'hFEA0, 8'h00, 0);
    step(LAT);
    chk("open_fea0", 16'(rdata1), 16'h00FF);
    req(1, 0, 16'hFFFF, 8'h00, 0);
    step(LAT);
    chk("open_ffff", 16'(rdata1), 16'h00FF);
    req(0, 1, 16'h4000, 8'h77, 0);
    step(1);

    // reset one cycle after a read accept drops the read
    req(1, 0, 16'h0040, 8'h00, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_due.delete();
    q_dat.delete();
    busy_from = -1;
    busy_to   = -2;
    m_boot    = 1'b1;
    m_rdata   = 8'hFF;
    chk("midreset_boot_active", 16'(ba1), 16'd1);
    chk("midreset_rdata", 16'(rdata1), 16'h00FF);
    chk("midreset_busy", 16'(busy1), 16'd0);
    step(3);

    // overlay boundary after re-enable
    req(1, 0, 16'h00FF, 8'h00, 0);
    step(LAT);
    chk("boot_edge_data", 16'(rdata1), 16'h0030);
    req(1, 0, 16'h0100, 8'h00, 0);
    step(LAT);
    chk("cart_edge_data", 16'(rdata1), 16'h00C2);

    step(4);
    chk("queue_drained", 16'(q_due.size()), 16'd0);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
